// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Brief    : Multi-read-port integer register file with issue scoreboard.
//             Register 0 is hard-wired to zero. Each register tracks whether
//             a producer is in flight and the tag of that producer.
//             Optional feature macro: REGFILE_BYPASS_EN (same-cycle
//             forwarding of writeback data and post-edge busy/tag status on
//             every read port).
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int TAG_W  = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [TAG_W-1:0]         wb_tag,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [TAG_W-1:0]         iss_tag,
    input  logic                     flush,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [NUM_RD*TAG_W-1:0]  rd_tag,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [c_depth];
    logic [TAG_W-1:0]  r_tag  [c_depth];
    logic [c_depth-1:0] r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic w_wb_act;
    logic w_iss_act;
    logic w_clr;
    logic w_inc;
    logic w_dec;

    // Qualify writeback/issue and decide scoreboard clear and counter deltas
    always_comb begin
        w_wb_act  = wb_en  && (wb_addr  != '0);
        w_iss_act = iss_en && (iss_addr != '0);
        // Only the producer currently holding the reservation may release it
        w_clr     = w_wb_act && r_busy[wb_addr] && (r_tag[wb_addr] == wb_tag);
        w_inc     = w_iss_act && !r_busy[iss_addr];
        // A same-register issue re-reserves the entry, so no net release
        w_dec     = w_clr && !(w_iss_act && (iss_addr == wb_addr));
    end

    // Register data, scoreboard and busy counter update
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < c_depth; k++) begin
                r_regs[k] <= '0;
                r_tag[k]  <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else if (rdy_in) begin
            if (w_wb_act) begin
                r_regs[wb_addr] <= wb_data;
            end
            if (flush) begin
                // Mispredict: every reservation is dropped, including a
                // same-cycle issue; the writeback data above still lands
                for (int k = 0; k < c_depth; k++) begin
                    r_tag[k] <= '0;
                end
                r_busy     <= '0;
                r_busy_cnt <= '0;
            end else begin
                if (w_clr) begin
                    r_busy[wb_addr] <= 1'b0;
                    r_tag[wb_addr]  <= '0;
                end
                // Issue is written last so it wins over a same-register clear
                if (w_iss_act) begin
                    r_busy[iss_addr] <= 1'b1;
                    r_tag[iss_addr]  <= iss_tag;
                end
                r_busy_cnt <= r_busy_cnt + {{ADDR_W{1'b0}}, w_inc}
                                         - {{ADDR_W{1'b0}}, w_dec};
            end
        end
    end

    assign busy_cnt = rst_in ? '0 : r_busy_cnt;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;
        logic [TAG_W-1:0]  w_tag;

        assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

        // Per-port combinational operand and status lookup
        always_comb begin
            w_data = r_regs[w_addr];
            w_busy = r_busy[w_addr];
            w_tag  = r_tag[w_addr];
`ifdef REGFILE_BYPASS_EN
            // Present the value the state will hold after the coming edge
            if (rdy_in) begin
                if (w_wb_act && (wb_addr == w_addr)) begin
                    w_data = wb_data;
                end
                if (flush) begin
                    w_busy = 1'b0;
                    w_tag  = '0;
                end else if (w_iss_act && (iss_addr == w_addr)) begin
                    w_busy = 1'b1;
                    w_tag  = iss_tag;
                end else if (w_clr && (wb_addr == w_addr)) begin
                    w_busy = 1'b0;
                    w_tag  = '0;
                end
            end
`endif
            if (rst_in || !rd_en[gi] || (w_addr == '0)) begin
                w_data = '0;
                w_busy = 1'b0;
                w_tag  = '0;
            end else if (!w_busy) begin
                w_tag  = '0;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = w_data;
        assign rd_busy[gi]                  = w_busy;
        assign rd_tag[gi*TAG_W +: TAG_W]    = w_tag;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with an attached issue scoreboard for the EPU pipeline. It sits between decode/issue and writeback. It holds 2^ADDR_W architectural registers, with register 0 hard-wired to zero. It tracks which registers have an in-flight producer, identified by tag, and supplies operand data and busy/tag status to every read port in the same cycle.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NUM_RD, 2, number of read ports
- TAG_W, 4, producer tag width

Ports (one clock; reset is synchronous and active-high):
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  when low, all state frozen; combinational outputs still valid
- wb_en  input  1  writeback valid
- wb_addr  input  ADDR_W  writeback destination
- wb_data  input  DATA_W  writeback value
- wb_tag  input  TAG_W  tag of completing producer
- iss_en  input  1  issue valid; marks destination busy
- iss_addr  input  ADDR_W  issued destination
- iss_tag  input  TAG_W  tag of new producer
- flush  input  1  clear all busy bits (mispredict)
- rd_en  input  NUM_RD  per-port read enable
- rd_addr  input  NUM_RD*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  operand value per port
- rd_busy  output  NUM_RD  operand has a pending producer
- rd_tag  output  NUM_RD*TAG_W  pending producer tag; 0 when not busy
- busy_cnt  output  ADDR_W+1  number of registers currently busy

## Operation
State:
- regs[2^ADDR_W] of DATA_W bits
- busy[2^ADDR_W]
- tag[2^ADDR_W]
- busy_cnt counter

Reset (rst_in high at posedge):
- all regs, busy, tag and busy_cnt go to 0.
- While rst_in is high, rd_data, rd_busy, rd_tag and busy_cnt outputs are forced to 0.

Writeback (posedge, rdy_in=1, wb_en=1, wb_addr≠0):
- regs[wb_addr] ← wb_data.
- busy[wb_addr] clears only if busy[wb_addr]=1 and tag[wb_addr]=wb_tag. A stale producer writes data but does not clear the newer reservation.

Issue (posedge, rdy_in=1, iss_en=1, iss_addr≠0):
- busy[iss_addr] ← 1 and tag[iss_addr] ← iss_tag.
- Issue to an already-busy register overwrites the tag.

Simultaneous events at the same register:
- Issue beats writeback-clear: busy stays 1 with iss_tag, and the data write still happens.
- Flush beats issue and writeback-clear: all busy bits go to 0 and all tags go to 0. The writeback data write still happens. An issue in the flush cycle is dropped.

busy_cnt tracks the popcount of busy after each edge:
- +1 on issue to a non-busy register.
- −1 on a matching clear without a same-cycle issue.
- Reset to 0 on flush.
- Saturation is never reached, since at most 2^ADDR_W−1 registers can be busy.

Address 0:
- Writes and issues to address 0 are ignored.
- Reads of address 0 return data 0, busy 0, tag 0.

Read ports:
- Purely combinational and independent.
- rd_en[i]=0 yields 0 on all of port i's outputs.

rdy_in=0:
- No register, busy, tag or counter update, including flush.
- Read outputs reflect the held state.

## Timing
- Read latency 0 cycles (combinational from rd_addr and state).
- Write, issue, flush and clear take effect at the next posedge; visible to reads in the following cycle, or the same cycle with bypass enabled.
- busy_cnt is registered and valid the cycle after the causing edge.
- Reset takes one edge; outputs are 0 throughout the reset cycle.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle forwarding on every read port.
  - rd_data = wb_data when wb_en & rdy_in & wb_addr=rd_addr≠0.
  - rd_busy/rd_tag show the post-edge value: cleared on a matching wb_tag, set with iss_tag on an issue to that address, cleared on flush.
- Undefined: read ports show pre-edge stored state only; no forwarding logic.

## Test plan
- **Reset:** reset, then read all addresses on both ports -> data 0, busy 0, busy_cnt 0.
- **Issue then writeback:** issue r5 tag 3, next cycle read r5 -> busy 1, tag 3, busy_cnt 1. Then wb r5 data 0xDEADBEEF tag 3; after the edge, read r5 -> data 0xDEADBEEF, busy 0, busy_cnt 0.
- **Stale producer:** issue r7 tag 1, then issue r7 tag 2, then wb r7 tag 1 data 0x11 -> data 0x11, busy 1, tag 2, busy_cnt 1.
- **Same-cycle issue and writeback:** one edge with iss r9 tag 4 and wb r9 tag 4 data 0x22 -> busy 1, tag 4, data 0x22.
- **Bypass:** with REGFILE_BYPASS_EN, wb r3 data 0x55 while port 1 reads r3 -> rd_data 0x55 in that cycle. Without the macro -> old value; 0x55 appears the next cycle.
- **Flush, zero register, rdy_in:**
  - Issue r2, r4, r6, then flush -> busy_cnt 0.
  - Write r0 with 0xFFFF_FFFF -> r0 reads 0.
  - Hold rdy_in=0 during wb r8 -> r8 unchanged.
